// File: rtl/bit_serial_bitwise_unit.sv
// bit_serial_bitwise_unit
//   Bit-serial AND/OR/XOR/NAND unit. It accepts one N-bit operand pair and an
//   op code through a valid/ready handshake. It then evaluates W bits per clock
//   on a single W-bit logic slice, starting with the LSB slice. The N-bit result
//   is returned through a second valid/ready handshake.
//
// Parameters
//   N  operand/result width (multiple of W)
//   W  bits processed per cycle (1 <= W <= N)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair and op valid
//   in_ready   unit idle, can accept operands
//   a, b       N-bit operands
//   op         00 AND, 01 OR, 10 XOR, 11 NAND
//   out_valid  result c valid
//   out_ready  consumer accepts result
//   c          N-bit result
//   busy       operation in progress or result waiting
module bit_serial_bitwise_unit #(
   parameter int unsigned N = 32,
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [1:0]   op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] c,
   output logic         busy
);

   localparam int unsigned NS = N / W;
   localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;
   localparam logic [CW-1:0] LAST_SLICE = CW'(NS - 1);
   localparam logic [W-1:0]  SLICE_ONES = '1;

   generate
      if (W < 1 || W > N || (N % W) != 0) begin : g_bad_params
         $error("bit_serial_bitwise_unit: N must be a multiple of W and 1 <= W <= N");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  a_q, a_d;
   logic [N-1:0]  b_q, b_d;
   logic [1:0]    op_q, op_d;
   logic [N-1:0]  c_q, c_d;

   // Single W-bit slice datapath: the active slice is shifted down to bit 0,
   // evaluated, and shifted back into place in c.
   int unsigned   sh;
   logic [W-1:0]  sa, sb, res;

   always_comb begin
      sh  = 32'(cnt_q) * W;
      sa  = W'(a_q >> sh);
      sb  = W'(b_q >> sh);
      res = '0;
      case (op_q)
         2'b00:   res = sa & sb;
         2'b01:   res = sa | sb;
         2'b10:   res = sa ^ sb;
         default: res = ~(sa & sb);
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      c_d     = c_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               op_d    = op;
               cnt_d   = '0;
               c_d     = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            c_d = (c_q & ~(N'(SLICE_ONES) << sh)) | (N'(res) << sh);
            if (cnt_q == LAST_SLICE) begin
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         op_q    <= '0;
         c_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         c_q     <= c_d;
      end
   end

   // Outputs depend on registered state only.
   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
   assign c         = c_q;

endmodule

// File: tb/tb_bit_serial_bitwise_unit.sv
// Testbench for bit_serial_bitwise_unit: behavioural model plus per-cycle
// compare, directed test-plan vectors, and W=1 / W=N companion instances.
module tb_bit_serial_bitwise_unit;

   localparam int unsigned N  = 32;
   localparam int unsigned W  = 8;
   localparam int unsigned NS = N / W;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [N-1:0]  a = '0;
   logic [N-1:0]  b = '0;
   logic [1:0]    op = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [N-1:0]  c;
   logic          busy;

   // Shared stimulus for the W=1 and W=N instances
   logic          x_in_valid = 1'b0;
   logic [N-1:0]  x_a = '0;
   logic [N-1:0]  x_b = '0;
   logic [1:0]    x_op = '0;
   logic          x_out_ready = 1'b0;
   logic          w1_in_ready, w1_out_valid, w1_busy;
   logic [N-1:0]  w1_c;
   logic          wn_in_ready, wn_out_valid, wn_busy;
   logic [N-1:0]  wn_c;

   int            checks = 0;
   int            errors = 0;
   logic          chk_en = 1'b0;

   always #5 clk = ~clk;

   bit_serial_bitwise_unit #(.N(N), .W(W)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
      .c(c), .busy(busy)
   );

   bit_serial_bitwise_unit #(.N(N), .W(1)) u_w1 (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(w1_in_ready),
      .a(x_a), .b(x_b), .op(x_op), .out_valid(w1_out_valid), .out_ready(x_out_ready),
      .c(w1_c), .busy(w1_busy)
   );

   bit_serial_bitwise_unit #(.N(N), .W(N)) u_wn (
      .clk(clk), .rst_n(rst_n), .in_valid(x_in_valid), .in_ready(wn_in_ready),
      .a(x_a), .b(x_b), .op(x_op), .out_valid(wn_out_valid), .out_ready(x_out_ready),
      .c(wn_c), .busy(wn_busy)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] ref_f(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [1:0] o);
      case (o)
         2'd0:    return x & y;
         2'd1:    return x | y;
         2'd2:    return x ^ y;
         default: return ~(x & y);
      endcase
   endfunction

   function automatic logic [N-1:0] lowmask(input int unsigned k);
      logic [63:0] m;
      m = (64'd1 << (k * W)) - 64'd1;
      return m[N-1:0];
   endfunction

   // ---------------- behavioural model ----------------
   // One pending operation at a time: accepted at edge m_acc, result visible
   // NS edges later, released on the first edge with out_ready while visible.
   int unsigned   cyc = 0;
   logic          m_pend = 1'b0;
   int unsigned   m_acc = 0;
   logic [N-1:0]  m_exp = '0;
   logic [N-1:0]  m_last = '0;
   int            m_done = 0;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pend = 1'b0;
            m_last = '0;
         end else begin
            cyc = cyc + 1;
            if (m_pend) begin
               if ((cyc - 1 >= m_acc + NS) && out_ready) begin
                  m_pend = 1'b0;
                  m_last = m_exp;
                  m_done++;
               end
            end else if (in_valid) begin
               m_pend = 1'b1;
               m_acc  = cyc;
               m_exp  = ref_f(a, b, op);
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   int            dut_hs = 0;
   initial begin
      int unsigned j;
      int unsigned k;
      logic        exp_ov;
      logic [N-1:0] exp_c;
      forever begin
         @(negedge clk);
         if (chk_en) begin
            j      = cyc - m_acc;
            k      = (j > NS) ? NS : j;
            exp_ov = m_pend && (j >= NS);
            exp_c  = m_pend ? (m_exp & lowmask(k)) : m_last;
            chk("cyc_in_ready", in_ready, !m_pend);
            chk("cyc_out_valid", out_valid, exp_ov);
            chk("cyc_busy", busy, m_pend);
            chk("cyc_c", c, exp_c);
            if (out_valid && out_ready) dut_hs++;
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic [1:0] top, input logic [N-1:0] expc, input string nm);
      int n;
      a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin
         step();
         n++;
      end
      chk({nm, "_latency"}, n, NS);
      chk({nm, "_c"}, c, expc);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({nm, "_idle"}, in_ready, 1'b1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int lat1, latn;
      logic [N-1:0] c1, cn;
      int done0;

      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_in_ready", in_ready, 1'b1);
      chk("reset_out_valid", out_valid, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_c", c, 32'h0);
      step();

      // Test-plan vectors
      do_op(32'hF0F01234, 32'hFF0000FF, 2'd0, 32'hF0000034, "and");
      do_op(32'hF0F01234, 32'hFF0000FF, 2'd1, 32'hFFF012FF, "or");
      do_op(32'hF0F01234, 32'hFF0000FF, 2'd2, 32'h0FF012CB, "xor");
      do_op(32'hF0F01234, 32'hFF0000FF, 2'd3, 32'h0FFFFFCB, "nand");

      // Stall in DONE while inputs toggle
      a = 32'hF0F01234; b = 32'hFF0000FF; op = 2'd2; in_valid = 1'b1; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      repeat (NS) step();
      for (int i = 0; i < 10; i++) begin
         a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
         in_valid = 1'($urandom_range(0, 1));
         step();
         chk("stall_c", c, 32'h0FF012CB);
         chk("stall_out_valid", out_valid, 1'b1);
         chk("stall_in_ready", in_ready, 1'b0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("stall_release", in_ready, 1'b1);

      // Asynchronous reset in the middle of RUN
      a = 32'hF0F01234; b = 32'hFF0000FF; op = 2'd1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      repeat (3) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_c", c, 32'h0);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_in_ready", in_ready, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      step();
      rst_n = 1'b1;
      repeat (8) step();
      chk("midrst_no_stale", out_valid, 1'b0);

      // W=1 and W=N companion instances
      x_a = 32'hAAAAAAAA; x_b = 32'h55555555; x_op = 2'd2;
      x_in_valid = 1'b1; x_out_ready = 1'b1;
      step();
      x_in_valid = 1'b0;
      lat1 = 0; latn = 0; c1 = '0; cn = '0;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (w1_out_valid && lat1 == 0) begin lat1 = i; c1 = w1_c; end
         if (wn_out_valid && latn == 0) begin latn = i; cn = wn_c; end
      end
      chk("w1_latency", lat1, 32);
      chk("w1_c", c1, 32'hFFFFFFFF);
      chk("wn_latency", latn, 1);
      chk("wn_c", cn, 32'hFFFFFFFF);

      // Random back-to-back operations
      done0 = m_done;
      n = 0;
      while ((m_done - done0) < 100 && n < 4000) begin
         in_valid  = 1'b1;
         a         = $urandom;
         b         = $urandom;
         op        = 2'($urandom_range(0, 3));
         out_ready = 1'($urandom_range(0, 1));
         step();
         n++;
      end
      chk("random_ops_completed", (m_done - done0) >= 100, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (NS + 4) step();
      out_ready = 1'b0;
      step();
      chk("handshake_count", dut_hs, m_done);
      chk("final_idle", in_ready, 1'b1);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
